// File: rtl/led_scan_scheduler_pkg.sv
// led_scan_scheduler_pkg: shared LED panel constants, timing defaults and scheduler state encoding
package led_scan_scheduler_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_BLANK,
    ST_LATCH,
    ST_SHOW
  } state_e;
  localparam int LED_ADDR_WIDTH = 3;
  localparam int LED_PLANES = 8;
  localparam int LED_BASE_TICKS = 16;
  localparam int LED_BLANK_TICKS = 4;
  localparam int LED_PANEL_COLS = 64;
  localparam int LED_COLOR_CH = 3;
  localparam logic [7:0] LED_DIM_FULL = 8'hFF;
  function automatic logic [15:0] show_len(input logic [15:0] base, input logic [2:0] plane);
    return base << plane;
  endfunction
endpackage

// File: rtl/led_dim_pwm.sv
// led_dim_pwm: free-running 8-bit dim counter and brightness comparator
//   clk, reset     : clock, sync active-high reset (clears counter)
//   brightness[7:0]: global dimming level, FF = always lit, 0 = never lit
//   lit            : high when the panel may be driven this cycle
module led_dim_pwm
  import led_scan_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] brightness,
  output logic       lit
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + 8'd1;
  always_ff @(posedge clk) cnt_q <= reset ? 8'd0 : cnt_d;
  assign lit = (brightness == LED_DIM_FULL) || (cnt_q < brightness);
endmodule

// File: rtl/led_scan_scheduler.sv
// led_scan_scheduler: double-buffered row/bit-plane scan scheduler for a multiplexed LED panel
//   clk, reset                   : clock, sync active-high reset
//   brightness[7:0]              : global dimming
//   shift_start/row/plane        : request to the column shifter (row/plane held until shift_done)
//   shift_done                   : shifter load complete
//   latch_out, addr_out          : panel latch strobe and row select
//   enable_out                   : panel output enable, active low
//   frame_start                  : pulse with the latch of row 0 plane 0
//   overrun                      : SHOW expired before the next shift finished
module led_scan_scheduler
  import led_scan_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH  = LED_ADDR_WIDTH,
  parameter int PLANES      = LED_PLANES,
  parameter int BASE_TICKS  = LED_BASE_TICKS,
  parameter int BLANK_TICKS = LED_BLANK_TICKS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            brightness,
  output logic                  shift_start,
  output logic [ADDR_WIDTH-1:0] shift_row,
  output logic [2:0]            shift_plane,
  input  logic                  shift_done,
  output logic                  latch_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  enable_out,
  output logic                  frame_start,
  output logic                  overrun
);
  state_e state_q, state_d;
  logic shift_start_q, shift_start_d;
  logic [ADDR_WIDTH-1:0] shift_row_q, shift_row_d, addr_q, addr_d;
  logic [2:0] shift_plane_q, shift_plane_d, disp_plane_q, disp_plane_d;
  logic [15:0] blank_q, blank_d, timer_q, timer_d;
  logic done_q, done_d, wait_q, wait_d;
  logic lit, expire, last_plane;
  led_dim_pwm u_dim (
    .clk       (clk),
    .reset     (reset),
    .brightness(brightness),
    .lit       (lit)
  );
  assign last_plane = shift_plane_q == 3'(PLANES - 1);
  // expiry is reported once; afterwards wait_q holds SHOW until the late shift lands
  assign expire = (state_q == ST_SHOW) && (timer_q == '0) && !wait_q;
  always_comb begin
    state_d       = state_q;
    shift_start_d = 1'b0;
    shift_row_d   = shift_row_q;
    shift_plane_d = shift_plane_q;
    addr_d        = addr_q;
    disp_plane_d  = disp_plane_q;
    blank_d       = blank_q;
    timer_d       = timer_q;
    done_d        = done_q;
    wait_d        = wait_q;
    case (state_q)
      ST_IDLE: begin
        state_d       = ST_FILL;
        shift_start_d = 1'b1;
      end
      ST_FILL: begin
        state_d = shift_done ? ST_BLANK : ST_FILL;
        blank_d = 16'(BLANK_TICKS - 1);
      end
      ST_BLANK: begin
        state_d      = (blank_q == '0) ? ST_LATCH : ST_BLANK;
        blank_d      = blank_q - 16'd1;
        addr_d       = shift_row_q;
        disp_plane_d = shift_plane_q;
      end
      ST_LATCH: begin
        // start shifting the following pair while this one is on display
        state_d       = ST_SHOW;
        shift_start_d = 1'b1;
        shift_plane_d = last_plane ? 3'd0 : shift_plane_q + 3'd1;
        shift_row_d   = last_plane ? shift_row_q + ADDR_WIDTH'(1) : shift_row_q;
        timer_d       = show_len(16'(BASE_TICKS), disp_plane_q) - 16'd1;
        done_d        = 1'b0;
        wait_d        = 1'b0;
      end
      ST_SHOW: begin
        done_d  = done_q | shift_done;
        blank_d = 16'(BLANK_TICKS - 1);
        timer_d = (timer_q == '0) ? timer_q : timer_q - 16'd1;
        wait_d  = wait_q | (expire && !done_q && !shift_done);
        state_d = (wait_q ? shift_done : (timer_q == '0) && (done_q || shift_done)) ? ST_BLANK : ST_SHOW;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shift_start_q <= 1'b0;
      shift_row_q   <= '0;
      shift_plane_q <= '0;
      addr_q        <= '0;
      disp_plane_q  <= '0;
      blank_q       <= '0;
      timer_q       <= '0;
      done_q        <= 1'b0;
      wait_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_start_q <= shift_start_d;
      shift_row_q   <= shift_row_d;
      shift_plane_q <= shift_plane_d;
      addr_q        <= addr_d;
      disp_plane_q  <= disp_plane_d;
      blank_q       <= blank_d;
      timer_q       <= timer_d;
      done_q        <= done_d;
      wait_q        <= wait_d;
    end
  end
  assign shift_start = shift_start_q;
  assign shift_row   = shift_row_q;
  assign shift_plane = shift_plane_q;
  assign addr_out    = addr_q;
  assign latch_out   = state_q == ST_LATCH;
  assign frame_start = latch_out && (shift_row_q == '0) && (shift_plane_q == '0);
  assign overrun     = expire && !done_q && !shift_done;
  assign enable_out  = !((state_q == ST_SHOW) && !wait_q && !overrun && lit);
endmodule

// File: tb/tb_led_scan_scheduler.sv
// tb_led_scan_scheduler: directed checks of scan order, timing, overrun, dimming and reset
module tb_led_scan_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic shift_done = 1'b0;
  logic [7:0] brightness = 8'hFF;
  logic shift_start, latch_out, enable_out, frame_start, overrun;
  logic shift_row, addr_out;
  logic [2:0] shift_plane;
  led_scan_scheduler #(.ADDR_WIDTH(1), .PLANES(2), .BASE_TICKS(4), .BLANK_TICKS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .brightness (brightness),
    .shift_start(shift_start),
    .shift_row  (shift_row),
    .shift_plane(shift_plane),
    .shift_done (shift_done),
    .latch_out  (latch_out),
    .addr_out   (addr_out),
    .enable_out (enable_out),
    .frame_start(frame_start),
    .overrun    (overrun)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  int lat_cyc[8], lat_addr[8], lat_fs[8], low_cnt[8], st_cyc[8], st_pair[8];
  int nlat, nst, ovr_n, ovr_first, fs_stray;
  logic en_log[1024];
  logic ref_en[1024];
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Resets the DUT (with shift_done high during reset, which must be ignored),
  // then runs ncyc cycles with a shifter answering dly cycles after each start.
  // Cycle 0 is the first cycle after the reset edge. Ends at a negedge.
  task automatic run(input int dly, input int ncyc, input int spur0, input int spur1);
    int cnt = 0;
    nlat = 0; nst = 0; ovr_n = 0; ovr_first = -1; fs_stray = 0;
    for (int k = 0; k < 8; k++) low_cnt[k] = 0;
    reset = 1'b1;
    shift_done = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      reset = 1'b0;
      shift_done = (i == spur0) || (i == spur1);
      if (shift_start) cnt = dly;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) shift_done = 1'b1;
      end
      #1;
      if (i == 0) begin
        check("rst_shift_start", shift_start, 0);
        check("rst_shift_row", shift_row, 0);
        check("rst_shift_plane", shift_plane, 0);
        check("rst_latch", latch_out, 0);
        check("rst_addr", addr_out, 0);
        check("rst_enable", enable_out, 1);
        check("rst_frame_start", frame_start, 0);
        check("rst_overrun", overrun, 0);
      end
      if (i == 1) check("first_shift_start", shift_start, 1);
      if (latch_out && nlat < 8) begin
        lat_cyc[nlat] = i; lat_addr[nlat] = addr_out; lat_fs[nlat] = frame_start; nlat++;
      end else if (!enable_out && nlat > 0 && nlat <= 8) low_cnt[nlat-1]++;
      if (frame_start && !latch_out) fs_stray++;
      if (shift_start && nst < 8) begin
        st_cyc[nst] = i; st_pair[nst] = shift_row * 8 + int'(shift_plane); nst++;
      end
      if (overrun) begin
        ovr_n++;
        if (ovr_first < 0) ovr_first = i;
      end
      if (i < 1024) en_log[i] = enable_out;
    end
  endtask
  // Expected trace for delay 3: FILL 1..4, BLANK 5..6, LATCH 7, SHOW 8..11 (done lands on expiry), ...
  task automatic check_nominal(input string tag);
    int e_lat[5] = '{7, 14, 25, 32, 43};
    int e_addr[5] = '{0, 0, 1, 1, 0};
    int e_fs[5] = '{1, 0, 0, 0, 1};
    int e_low[4] = '{4, 8, 4, 8};
    int e_st[5] = '{1, 8, 15, 26, 33};
    int e_pair[5] = '{0, 1, 8, 9, 0};
    check({tag, "_nlat"}, nlat >= 5, 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_latch%0d_cycle", tag, k), lat_cyc[k], e_lat[k]);
      check($sformatf("%s_latch%0d_addr", tag, k), lat_addr[k], e_addr[k]);
      check($sformatf("%s_latch%0d_fs", tag, k), lat_fs[k], e_fs[k]);
      check($sformatf("%s_start%0d_cycle", tag, k), st_cyc[k], e_st[k]);
      check($sformatf("%s_start%0d_pair", tag, k), st_pair[k], e_pair[k]);
    end
    for (int k = 0; k < 4; k++) check($sformatf("%s_show%0d_len", tag, k), low_cnt[k], e_low[k]);
    check({tag, "_overrun"}, ovr_n, 0);
    check({tag, "_fs_stray"}, fs_stray, 0);
  endtask
  initial begin
    int err, got_low, exp_low;
    run(3, 50, -1, -1);
    check_nominal("nominal");
    // shifter slow: SHOW 15..18 expires at 18, done at 25, BLANK 26..27, LATCH 28
    run(10, 29, -1, -1);
    check("slow_latch0", lat_cyc[0], 14);
    check("slow_latch1", lat_cyc[1], 28);
    check("slow_overrun_n", ovr_n, 1);
    check("slow_overrun_cycle", ovr_first, 18);
    check("slow_lit_cycles", low_cnt[0], 3);
    // stop in the middle of the plane-1 SHOW (15..22), then reset
    run(3, 18, -1, -1);
    run(3, 50, -1, -1);
    check_nominal("after_reset");
    run(3, 50, 5, 7);
    check_nominal("spurious");
    run(3, 1024, -1, -1);
    for (int i = 0; i < 1024; i++) ref_en[i] = en_log[i];
    brightness = 8'h80;
    run(3, 1024, -1, -1);
    err = 0; got_low = 0; exp_low = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!ref_en[i] && (i % 256) < 128) exp_low++;
      if (!en_log[i]) got_low++;
      if (en_log[i] !== ((!ref_en[i] && (i % 256) < 128) ? 1'b0 : 1'b1)) err++;
    end
    check("dim80_pattern_errs", err, 0);
    check("dim80_lit_count", got_low, exp_low);
    brightness = 8'h00;
    run(3, 1024, -1, -1);
    got_low = 0;
    for (int i = 0; i < 1024; i++) if (!en_log[i]) got_low++;
    check("dim0_lit_count", got_low, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/led_scan_scheduler.md
LED_SCAN_SCHEDULER -- requirements
Module: led_scan_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: panel row-address bits; rows = 2^ADDR_WIDTH.
REQ-002 Parameter PLANES, default 8: bit planes per row (binary-coded modulation), 1..8.
REQ-003 Parameter BASE_TICKS, default 16: SHOW duration of plane 0, in clk cycles, >=1.
REQ-004 Parameter BLANK_TICKS, default 4: blanking cycles before each latch, >=1.
REQ-005 clk  in  1  sole clock; all logic on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 brightness  in  8  global dimming; 8'hFF = full on, 0 = always off.
REQ-008 shift_start  out  1  one-cycle pulse: shifter begins loading shift_row/shift_plane.
REQ-009 shift_row  out  ADDR_WIDTH  row the shifter shall load; stable from shift_start until shift_done.
REQ-010 shift_plane  out  3  plane the shifter shall load; same stability rule.
REQ-011 shift_done  in  1  one-cycle pulse from the shifter: load complete.
REQ-012 latch_out  out  1  panel latch, high for exactly one cycle per plane.
REQ-013 addr_out  out  ADDR_WIDTH  panel row select.
REQ-014 enable_out  out  1  panel output enable, active low (1 = dark).
REQ-015 frame_start  out  1  one-cycle pulse coincident with the latch of row 0 plane 0.
REQ-016 overrun  out  1  one-cycle pulse when a SHOW period expires before the next shift completes.

Function
REQ-017 States: IDLE, FILL, BLANK, LATCH, SHOW; scan order is plane 0..PLANES-1 within a row, then row+1, wrapping from (rows-1, PLANES-1) to (0,0).
REQ-018 IDLE lasts one cycle and then shall pulse shift_start for (0,0), entering FILL.
REQ-019 FILL shall hold enable_out=1 and move to BLANK on the cycle after shift_done.
REQ-020 BLANK shall hold enable_out=1 for exactly BLANK_TICKS cycles, then enter LATCH.
REQ-021 LATCH (one cycle): latch_out=1; addr_out and disp_plane take the loaded row/plane; frame_start=1 iff the loaded pair is (0,0); the next pair advances per REQ-017.
REQ-022 The first SHOW cycle shall pulse shift_start for the advanced pair (double-buffered overlap: display N while shifting N+1).
REQ-023 SHOW shall last BASE_TICKS<<disp_plane cycles; the SHOW timer is 16 bits and BASE_TICKS<<(PLANES-1) <= 65535.
REQ-024 During SHOW, enable_out=0 when brightness==8'hFF or a free-running 8-bit dim counter < brightness; otherwise 1.
REQ-025 A shift_done in SHOW sets a done flag; SHOW exits to BLANK on the cycle after the timer expires with the flag set, including when shift_done arrives in the expiry cycle.
REQ-026 On expiry without the flag: overrun pulses once; enable_out is forced to 1; the block stays in SHOW until shift_done, then enters BLANK the next cycle.
REQ-027 shift_done outside FILL/SHOW, or a second pulse in the same SHOW, shall be ignored.
REQ-028 shift_start shall never pulse while a previous shift is outstanding.

Reset
REQ-029 When reset is asserted: state=IDLE; shift_start=0; shift_row=0; shift_plane=0; latch_out=0; addr_out=0; enable_out=1; frame_start=0; overrun=0; timers, dim counter and done flag are cleared.
REQ-030 Reset mid-operation takes effect at the next edge; the outstanding shift is abandoned and shift_done is ignored while reset is high.

Structure
REQ-031 State encodings and the shared LED timing defaults (BASE_TICKS, BLANK_TICKS) shall reside in the shared LED panel include, alongside the panel constants used by the shifter.
REQ-032 The dim comparator and its counter shall be the single sub-module led_dim_pwm; all else is flat.

Verification
REQ-033 Configure ADDR_WIDTH=1, PLANES=2, BASE_TICKS=4, BLANK_TICKS=2, brightness=FF, shifter model answering 3 cycles after start -> latches at (0,0),(0,1),(1,0),(1,1),(0,0); SHOW lengths 4,8,4,8; frame_start only on (0,0) latches.
REQ-034 Same configuration, shifter delay 10 cycles -> overrun pulses once in the plane-0 SHOW, enable_out=1 from expiry until shift_done, BLANK entered the cycle after shift_done.
REQ-035 brightness=0 -> enable_out stays 1 in every cycle; brightness=8'h80 -> enable_out=0 in exactly 128 of every 256 SHOW cycles of the dim counter.
REQ-036 shift_done driven in the same cycle as SHOW timer expiry -> no overrun; BLANK entered the next cycle.
REQ-037 reset asserted for 1 cycle in the middle of SHOW -> all outputs match REQ-029 the following cycle; the sequence restarts with shift_start for (0,0) two cycles after reset deasserts.
REQ-038 Spurious shift_done pulses injected during BLANK and LATCH -> sequence and timing identical to REQ-033.
